// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic stream controller and its skew mux:
//   - state_t   : FSM state encoding (ST_IDLE .. ST_DONE)
//   - stream_len: number of stream slots for a SIZE x SIZE array (3*SIZE-2)
//   - idx_w     : width of a row/column index for a given SIZE
//   - cnt_w     : width of the stream-slot counter for a given SIZE
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Slots needed to push every operand through the far PE diagonal:
    // 2*SIZE-1 data-bearing slots plus SIZE-1 zero flush slots.
    function automatic int stream_len(input int size);
        return 3 * size - 2;
    endfunction

    function automatic int idx_w(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

    function automatic int cnt_w(input int size);
        return $clog2(3 * size);
    endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// -----------------------------------------------------------------------------
// systolic_skew_mux
// Combinational diagonal-skew selector for one edge of the systolic array.
// For stream slot t, lane l carries element k = t - l when 0 <= k < SIZE,
// otherwise zero.
//   COL_EDGE = 0 (west / rows)   : lane l = bank[l][k]
//   COL_EDGE = 1 (north / cols)  : lane l = bank[k][l]
// Ports:
//   t      in   stream slot index
//   bank   in   SIZE x SIZE operand bank
//   slices out  SIZE lanes of DATA_WIDTH, lane 0 in the low bits
// -----------------------------------------------------------------------------
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter  int SIZE       = 5,
    parameter  int DATA_WIDTH = 32,
    parameter  bit COL_EDGE   = 1'b0,
    localparam int CNT_W      = cnt_w(SIZE)
) (
    input  logic [CNT_W-1:0]                           t,
    input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0]  bank,
    output logic [SIZE-1:0][DATA_WIDTH-1:0]            slices
);

    // Matching t == lane + k avoids a subtraction that could wrap below zero;
    // at most one k matches per lane, so the unmatched case stays zero.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        slices = '0;
        for (int lane = 0; lane < SIZE; lane++) begin
            for (int k = 0; k < SIZE; k++) begin
                if (int'(t) == lane + k) begin
                    slices[lane] = COL_EDGE ? bank[k][lane] : bank[lane][k];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_stream_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_stream_ctrl
// Sequencer feeding a SIZE x SIZE output-stationary systolic array. Holds
// operand banks A and B (loaded through a write port while idle). A start
// pulse clears the array accumulators, streams skewed A rows west and B
// columns north, waits PE_LAT cycles for the PE pipeline, then pulses done.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_mat          write strobe, bank select (0 = A, 1 = B)
//   wr_row/wr_col/wr_data element index and value
//   wr_err                one-cycle pulse: write rejected (busy or bad index)
//   start                 begin-multiply pulse (ignored while busy)
//   busy                  high from CLEAR through DONE
//   arr_clr               one-cycle accumulator clear to the array
//   inp_west/inp_north    registered edge buses, slice i in bits [i*DW +: DW]
//   done                  one-cycle pulse: array results are final
// -----------------------------------------------------------------------------
module systolic_stream_ctrl
    import systolic_pkg::*;
#(
    parameter  int SIZE       = 5,
    parameter  int DATA_WIDTH = 32,
    parameter  int PE_LAT     = 2,
    localparam int IDX_W      = idx_w(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_mat,
    input  logic [IDX_W-1:0]           wr_row,
    input  logic [IDX_W-1:0]           wr_col,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_err,
    input  logic                       start,
    output logic                       busy,
    output logic                       arr_clr,
    output logic [SIZE*DATA_WIDTH-1:0] inp_west,
    output logic [SIZE*DATA_WIDTH-1:0] inp_north,
    output logic                       done
);

    localparam int                CNT_W    = cnt_w(SIZE);
    localparam logic [CNT_W-1:0]  LAST_T   = CNT_W'(stream_len(SIZE) - 1);
    localparam int                DRN_W    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(PE_LAT - 1);
    localparam logic [IDX_W:0]    SIZE_V   = (IDX_W + 1)'(SIZE);

    typedef logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] bank_t;
    typedef logic [SIZE-1:0][DATA_WIDTH-1:0]           edge_t;

    state_t           state;
    logic [CNT_W-1:0] t_cnt;
    logic [DRN_W-1:0] drn_cnt;
    bank_t            a_bank, b_bank;
    edge_t            west_q, north_q;
    edge_t            west_mux, north_mux;
    logic [CNT_W-1:0] mux_t;
    logic             wr_ok;

    // Writes land only while idle, which keeps the banks a stable snapshot
    // for the whole run.
    assign wr_ok = wr_en && (state == ST_IDLE)
                && ({1'b0, wr_row} < SIZE_V) && ({1'b0, wr_col} < SIZE_V);

    // Buses are registered, so the mux looks one slot ahead: slot 0 is
    // loaded on leaving CLEAR, slot t+1 while slot t is on the bus.
    always_comb begin
        mux_t = '0;
        if (state == ST_STREAM) begin
            mux_t = t_cnt + CNT_W'(1);
        end
    end

    systolic_skew_mux #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_EDGE   (1'b0)
    ) u_west_mux (
        .t      (mux_t),
        .bank   (a_bank),
        .slices (west_mux)
    );

    systolic_skew_mux #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .COL_EDGE   (1'b1)
    ) u_north_mux (
        .t      (mux_t),
        .bank   (b_bank),
        .slices (north_mux)
    );

    // NOTE: the operand banks are reset even though they are storage: a reset
    // must leave both matrices at zero, so this cannot map to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_bank <= '0;
            b_bank <= '0;
        end else if (wr_ok) begin
            if (wr_mat) begin
                b_bank[wr_row][wr_col] <= wr_data;
            end else begin
                a_bank[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            t_cnt   <= '0;
            drn_cnt <= '0;
            busy    <= 1'b0;
            arr_clr <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            arr_clr <= 1'b0;
            done    <= 1'b0;
            wr_err  <= wr_en && !wr_ok;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    state   <= ST_STREAM;
                    t_cnt   <= '0;
                    west_q  <= west_mux;
                    north_q <= north_mux;
                end

                ST_STREAM: begin
                    if (t_cnt == LAST_T) begin
                        t_cnt   <= '0;
                        drn_cnt <= '0;
                        west_q  <= '0;
                        north_q <= '0;
                        if (PE_LAT == 0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        t_cnt   <= t_cnt + CNT_W'(1);
                        west_q  <= west_mux;
                        north_q <= north_mux;
                    end
                end

                ST_DRAIN: begin
                    if (drn_cnt == DRN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drn_cnt <= drn_cnt + DRN_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign inp_west  = west_q;
    assign inp_north = north_q;

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_stream_ctrl
// Self-checking bench: a reference model of the operand banks, the skew rule
// applied slot by slot, and an output-stationary array emulation fed from the
// DUT buses whose result is compared with a plain matrix product.
// -----------------------------------------------------------------------------
module tb_systolic_stream_ctrl;

    localparam int SIZE     = 5;
    localparam int DW       = 32;
    localparam int PE_LAT   = 2;
    localparam int IDX_W    = $clog2(SIZE);
    localparam int SLEN     = 3 * SIZE - 2;
    localparam int BUSY_LEN = 1 + SLEN + PE_LAT + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_en = 1'b0;
    logic                 wr_mat = 1'b0;
    logic [IDX_W-1:0]     wr_row = '0;
    logic [IDX_W-1:0]     wr_col = '0;
    logic [DW-1:0]        wr_data = '0;
    logic                 wr_err;
    logic                 start = 1'b0;
    logic                 busy;
    logic                 arr_clr;
    logic [SIZE*DW-1:0]   inp_west;
    logic [SIZE*DW-1:0]   inp_north;
    logic                 done;

    systolic_stream_ctrl #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DW),
        .PE_LAT     (PE_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_mat    (wr_mat),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .start     (start),
        .busy      (busy),
        .arr_clr   (arr_clr),
        .inp_west  (inp_west),
        .inp_north (inp_north),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] ma [SIZE][SIZE];
    logic [DW-1:0] mb [SIZE][SIZE];
    logic [DW-1:0] w_hist [SLEN][SIZE];
    logic [DW-1:0] n_hist [SLEN][SIZE];
    logic [63:0]   res [SIZE][SIZE];

    typedef struct {
        bit            mat;
        int            row;
        int            col;
        logic [DW-1:0] data;
        bit            exp_err;
    } wr_vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice_of(input logic [SIZE*DW-1:0] bus, input int lane);
        return bus[lane*DW +: DW];
    endfunction

    // Skew rule: lane l in slot t carries element k = t - l if 0 <= k < SIZE.
    function automatic logic [DW-1:0] exp_slice(input bit col_edge, input int t, input int lane);
        int k;
        k = t - lane;
        if (t < 0 || t >= SLEN || k < 0 || k >= SIZE) return '0;
        return col_edge ? mb[k][lane] : ma[lane][k];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
    endtask

    // Called just after a negedge; leaves the bench just after the next one.
    task automatic do_write(input bit mat, input int row, input int col,
                            input logic [DW-1:0] data, input bit exp_err);
        wr_en   = 1'b1;
        wr_mat  = mat;
        wr_row  = IDX_W'(row);
        wr_col  = IDX_W'(col);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        check($sformatf("wr_err[%0d,%0d,%0d]", mat, row, col), wr_err, exp_err);
        if (!exp_err) begin
            if (mat) mb[row][col] = data;
            else     ma[row][col] = data;
        end
    endtask

    // Run one multiply. Checks every busy cycle against the model and
    // emulates the array from the observed buses.
    //   abort_at  : busy cycle at which rst is asserted (0 = none)
    //   restart_at: busy cycle at which a stray start is driven (0 = none)
    //   wr_at     : busy cycle at which a (rejected) write is driven (0 = none)
    task automatic run(input int abort_at, input int restart_at, input int wr_at);
        logic [63:0] acc;
        logic [63:0] want;
        int          tn;
        start = 1'b1;
        for (int c = 1; c <= BUSY_LEN; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            check($sformatf("busy@%0d", c), busy, 1'b1);
            check($sformatf("arr_clr@%0d", c), arr_clr, (c == 1));
            check($sformatf("done@%0d", c), done, (c == BUSY_LEN));
            check($sformatf("wr_err@%0d", c), wr_err, (wr_at != 0 && c == wr_at + 1));
            for (int l = 0; l < SIZE; l++) begin
                check($sformatf("west[%0d]@%0d", l, c), slice_of(inp_west, l), exp_slice(1'b0, c - 2, l));
                check($sformatf("north[%0d]@%0d", l, c), slice_of(inp_north, l), exp_slice(1'b1, c - 2, l));
                if (c >= 2 && c - 2 < SLEN) begin
                    w_hist[c-2][l] = slice_of(inp_west, l);
                    n_hist[c-2][l] = slice_of(inp_north, l);
                end
            end
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort busy", busy, 1'b0);
                check("abort arr_clr", arr_clr, 1'b0);
                check("abort done", done, 1'b0);
                check("abort west", inp_west, '0);
                check("abort north", inp_north, '0);
                return;
            end
            if (c == restart_at) start = 1'b1;
            if (c == wr_at) begin
                wr_en   = 1'b1;
                wr_mat  = 1'b0;
                wr_row  = IDX_W'(1);
                wr_col  = IDX_W'(1);
                wr_data = 32'hDEAD_BEEF;
            end
        end
        @(negedge clk);
        check("idle busy", busy, 1'b0);
        check("idle done", done, 1'b0);
        check("idle arr_clr", arr_clr, 1'b0);
        // PE(i,j) sees west slot tw of row i together with north slot
        // tw + j - i of column j; accumulate those pairs.
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                acc  = '0;
                want = '0;
                for (int tw = 0; tw < SLEN; tw++) begin
                    tn = tw + j - i;
                    if (tn >= 0 && tn < SLEN)
                        acc += 64'(w_hist[tw][i]) * 64'(n_hist[tn][j]);
                end
                for (int k = 0; k < SIZE; k++)
                    want += 64'(ma[i][k]) * 64'(mb[k][j]);
                res[i][j] = acc;
                check($sformatf("result[%0d][%0d]", i, j), acc, want);
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_vec_t vecs[8];
        int      row, col;

        vecs[0] = '{1'b0, 0, 0, 32'd7,   1'b0};
        vecs[1] = '{1'b0, 5, 0, 32'd11,  1'b1};
        vecs[2] = '{1'b1, 0, 6, 32'd12,  1'b1};
        vecs[3] = '{1'b1, 7, 7, 32'd13,  1'b1};
        vecs[4] = '{1'b1, 4, 4, 32'd9,   1'b0};
        vecs[5] = '{1'b0, 4, 5, 32'd14,  1'b1};
        vecs[6] = '{1'b0, 0, 0, 32'd0,   1'b0};
        vecs[7] = '{1'b1, 4, 4, 32'd404, 1'b0};

        clear_model();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset arr_clr", arr_clr, 1'b0);
        check("reset done", done, 1'b0);
        check("reset wr_err", wr_err, 1'b0);
        check("reset west", inp_west, '0);
        check("reset north", inp_north, '0);
        rst = 1'b0;
        @(negedge clk);

        // Banks are zero after reset
        run(0, 0, 0);

        // Skew pattern A[i][k] = 10i+k, B[k][j] = 100k+j
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                do_write(1'b0, i, j, DW'(10 * i + j), 1'b0);
                do_write(1'b1, i, j, DW'(100 * i + j), 1'b0);
            end
        // Index guards from the table; the final entries restore the pattern
        for (int v = 0; v < 8; v++)
            do_write(vecs[v].mat, vecs[v].row, vecs[v].col, vecs[v].data, vecs[v].exp_err);
        run(0, 0, 0);
        check("skew t0 west0", w_hist[0][0], 32'd0);
        check("skew t4 west4", w_hist[4][4], 32'd40);
        check("skew t4 north2", n_hist[4][2], 32'd202);
        check("skew t12 west4", w_hist[12][4], 32'd0);

        // Write in the same cycle as start is visible to the run
        wr_en   = 1'b1;
        wr_mat  = 1'b0;
        wr_row  = IDX_W'(2);
        wr_col  = IDX_W'(3);
        wr_data = 32'd999;
        ma[2][3] = 32'd999;
        run(0, 0, 0);

        // Stray start at busy cycle 3 and a write at busy cycle 5
        run(0, 3, 5);
        run(0, 0, 0);

        // End-to-end: A = 1..16, B = 17..32 in the top-left 4x4
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                do_write(1'b0, i, j, (i < 4 && j < 4) ? DW'(1 + 4 * i + j)  : '0, 1'b0);
                do_write(1'b1, i, j, (i < 4 && j < 4) ? DW'(17 + 4 * i + j) : '0, 1'b0);
            end
        run(0, 0, 0);
        check("e2e result[0][0]", res[0][0], 64'd250);
        check("e2e result[3][3]", res[3][3], 64'd1528);
        for (int k = 0; k < SIZE; k++) begin
            check($sformatf("e2e row4[%0d]", k), res[4][k], 64'd0);
            check($sformatf("e2e col4[%0d]", k), res[k][4], 64'd0);
        end

        // Identity B, then back-to-back runs: each result equals A
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                do_write(1'b1, i, j, (i == j) ? DW'(1) : '0, 1'b0);
        run(0, 0, 0);
        run(0, 0, 0);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                check($sformatf("identity[%0d][%0d]", i, j), res[i][j], 64'(ma[i][j]));

        // Randomised banks, including out-of-range write indices
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 40; n++) begin
                row = $urandom_range(0, 7);
                col = $urandom_range(0, 7);
                do_write(1'($urandom_range(0, 1)), row, col, DW'($urandom),
                         (row >= SIZE || col >= SIZE));
            end
            run(0, 0, 0);
        end

        // Reset mid-run: no done afterwards, banks cleared
        run(6, 0, 0);
        clear_model();
        repeat (2) begin
            @(negedge clk);
            check("in-reset done", done, 1'b0);
            check("in-reset busy", busy, 1'b0);
        end
        rst = 1'b0;
        repeat (BUSY_LEN) begin
            @(negedge clk);
            check("post-reset done", done, 1'b0);
            check("post-reset busy", busy, 1'b0);
        end
        run(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_stream_ctrl.md
Name: systolic_stream_ctrl

Overview:
Sequencer that feeds the SIZE x SIZE output-stationary systolic_array, replacing bench-driven stimulus. Holds operand matrices A and B in internal register banks loaded through a simple write port. On a start pulse it clears the array accumulators and streams A rows into the west edge and B columns into the north edge with the diagonal skew. It then waits out PE pipeline latency and signals done. It sits between the host/loader and systolic_array.

Parameters:
SIZE, 5, array dimension (rows = cols = SIZE); legal range 2..16
DATA_WIDTH, 32, operand element width
PE_LAT, 2, cycles after the last stream slot before all accumulators are final
IDX_W, $clog2(SIZE), derived local row/column index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  operand write strobe
wr_mat  in  1  0 = write A, 1 = write B
wr_row  in  IDX_W  element row index
wr_col  in  IDX_W  element column index
wr_data  in  DATA_WIDTH  element value
wr_err  out  1  one-cycle pulse: write rejected (busy, or index >= SIZE)
start  in  1  begin-multiply pulse
busy  out  1  high from CLEAR through DONE inclusive
arr_clr  out  1  one-cycle accumulator clear to systolic_array
inp_west  out  SIZE*DATA_WIDTH  west-edge bus; slice i = row i
inp_north  out  SIZE*DATA_WIDTH  north-edge bus; slice j = column j
done  out  1  one-cycle pulse: array results valid

Behaviour:
- Reset (async assert, sync release): state IDLE. busy, arr_clr, done and wr_err = 0. inp_west and inp_north = 0. Stream counter = 0. Both operand banks cleared to 0.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - wr_en with both indices < SIZE writes A[wr_row][wr_col] or B[wr_row][wr_col] at the clock edge.
  - start -> CLEAR.
  - start and wr_en in the same cycle: the write completes first, so it is visible to the run.
- CLEAR: one cycle. arr_clr = 1, busy = 1, buses = 0. Then STREAM with t = 0.
- STREAM: runs 3*SIZE-2 cycles, t = 0 .. 3*SIZE-3. Bus values are registered.
  - In the cycle where the counter = t: slice i of inp_west = A[i][t-i] if 0 <= t-i < SIZE, else 0.
  - In the same cycle: slice j of inp_north = B[t-j][j] if 0 <= t-j < SIZE, else 0.
  - The extra zero slots (t > 2*SIZE-2) flush the far PE diagonal.
  - When t = 3*SIZE-3 -> DRAIN.
- DRAIN: PE_LAT cycles, buses = 0. Then DONE.
- DONE: one cycle, done = 1. Then IDLE.
- busy duration: 1 + (3*SIZE-2) + PE_LAT + 1 cycles. For SIZE=5, PE_LAT=2 this is 17 cycles, with done in the 17th.
- start while busy is ignored; it is not queued.
- wr_en while busy: no write, and wr_err pulses the next cycle.
- wr_en in IDLE with wr_row >= SIZE or wr_col >= SIZE: no write, and wr_err pulses.
- Operand banks are not modified during a run, so a run always uses a consistent snapshot.
- rst asserted mid-run: immediate return to IDLE, buses = 0, banks cleared. No done pulse.
- Widths:
  - Stream counter width is $clog2(3*SIZE).
  - Index arithmetic is unsigned with an explicit range check; no negative wrap.
  - Element products and accumulation stay in the array (2*DATA_WIDTH); this block passes operands unchanged.

Decomposition:
- Shared package systolic_pkg holds:
  - state encoding localparams ST_IDLE..ST_DONE,
  - the STREAM_LEN = 3*SIZE-2 function,
  - the IDX_W helper.
- One sub-module, systolic_skew_mux. It is combinational and, given t, a bank and the edge type (row or column), produces the skewed SIZE*DATA_WIDTH slice vector. It is instantiated twice, once for A/west and once for B/north.
- Registers and the FSM stay in the top module.

Test Plan:
- Reset mid-run: assert rst at busy cycle 6 -> busy, arr_clr, done = 0 and buses = 0 within the same cycle; no done afterwards; subsequent reads show banks = 0.
- Skew check, SIZE=5: load A[i][k] = 10*i + k, B[k][j] = 100*k + j, then start. arr_clr lasts exactly 1 cycle. At t=0 the buses are west = {0,0,0,0,0} and north = {0,0,0,0,0} except slice 0 = A[0][0] = 0 and B[0][0] = 0. At t=4, west slice 4 = A[4][0] = 40 and north slice 2 = B[2][2] = 202. At t=12 all slices are 0. done rises exactly 17 cycles after the start edge.
- End-to-end with systolic_array, SIZE=5: A = 1..16 in the top-left 4x4, B = 17..32 in the top-left 4x4, all else 0. After done: result[0][0] = 250, result[3][3] = 1528, row 4 and column 4 = 0.
- Guards:
  - start pulsed at busy cycle 3 -> ignored, single done.
  - wr_en during busy -> wr_err pulses, bank unchanged.
  - wr_row = 5 in IDLE -> wr_err pulses, no write.
- Back-to-back runs: start in the cycle after done with a new B (identity) -> the second run's result equals A; arr_clr fires again, so there is no carry-over from run 1.
